nibble_serial_adder_ctrl: RTL and testbench

//  Sequencer that computes wide unsigned sums (4*NUM_NIBBLES bits + carry) by time-multiplexing
//  one shared combinational 4-bit ripple adder slice (a[3:0], b[3:0], carry_in -> sum[3:0], overflow).

---
 rtl/nibble_serial_adder_ctrl.sv | 106 ++++++++++
 tb/tb_nibble_serial_adder_ctrl.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder_ctrl.sv
// Wide unsigned adder that reuses one 4-bit ripple slice, one nibble per clock, LSB first.
// Handshake: start (sampled in IDLE), busy while adding, one-cycle done when sum/overflow update.
module nibble_serial_adder_ctrl #(
  parameter int unsigned NUM_NIBBLES = 4
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic                       start,
  input  logic [4*NUM_NIBBLES-1:0]   a,
  input  logic [4*NUM_NIBBLES-1:0]   b,
  input  logic                       carry_in,
  output logic                       busy,
  output logic                       done,
  output logic [4*NUM_NIBBLES-1:0]   sum,
  output logic                       overflow
);

  localparam int unsigned IDX_W = (NUM_NIBBLES > 1) ? $clog2(NUM_NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [NUM_NIBBLES-1:0][3:0] a_reg;
  logic [NUM_NIBBLES-1:0][3:0] b_reg;
  logic [NUM_NIBBLES-1:0][3:0] work;
  logic [NUM_NIBBLES-1:0][3:0] merged_c;
  logic                        carry_reg;
  logic [IDX_W-1:0]            idx;
  logic [3:0]                  slice_sum_c;
  logic                        slice_co_c;

  // Shared 4-bit slice fed by the current nibble pair and the running carry
  always_comb begin
    {slice_co_c, slice_sum_c} = 5'(a_reg[idx]) + 5'(b_reg[idx]) + 5'(carry_reg);
  end

  // Final result: accumulated nibbles with the one being computed this cycle
  always_comb begin
    merged_c      = work;
    merged_c[idx] = slice_sum_c;
  end

  always_ff @(posedge clk) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = ADD;
      ADD:     if (idx == LAST_IDX) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    busy = (state == ADD);
    done = (state == DONE);
  end

  // Operand capture, nibble accumulation and atomic publication of the result
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      work      <= '0;
      carry_reg <= 1'b0;
      idx       <= '0;
      sum       <= '0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_reg     <= a;
            b_reg     <= b;
            carry_reg <= carry_in;
            idx       <= '0;
          end
        end
        ADD: begin
          work[idx] <= slice_sum_c;
          carry_reg <= slice_co_c;
          if (idx == LAST_IDX) begin
            sum      <= merged_c;
            overflow <= slice_co_c;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Self-checking bench for nibble_serial_adder_ctrl (NUM_NIBBLES=4): directed cases plus
// a randomized back-to-back run checked against plain a+b+carry_in arithmetic.
module tb_nibble_serial_adder_ctrl;

  localparam int unsigned N = 4;
  localparam int unsigned W = 4 * N;

  logic         clk = 1'b0;
  logic         n_rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         carry_in;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         overflow;

  int tests    = 0;
  int failures = 0;

  always #5 clk = ~clk;

  nibble_serial_adder_ctrl #(.NUM_NIBBLES(N)) dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .start    (start),
    .a        (a),
    .b        (b),
    .carry_in (carry_in),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .overflow (overflow)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic scramble();
    a        = W'($urandom);
    b        = W'($urandom);
    carry_in = 1'($urandom);
  endtask

  // One transaction: pulse start, then verify latency, busy, result and the single-cycle done
  task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic tci);
    logic [W:0] exp;
    int         k;
    exp = (W+1)'(ta) + (W+1)'(tb_v) + (W+1)'(tci);
    @(negedge clk);
    a = ta; b = tb_v; carry_in = tci; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    scramble();
    k = 1;
    while (!done && k < 20) begin
      check({tag, "_busy"}, 64'(busy), 64'd1);
      @(negedge clk);
      k++;
    end
    check({tag, "_latency"}, 64'(k - 1), 64'(N));
    check({tag, "_sum"}, 64'(sum), 64'(exp[W-1:0]));
    check({tag, "_ovf"}, 64'(overflow), 64'(exp[W]));
    check({tag, "_busy_done"}, 64'(busy), 64'd0);
    @(negedge clk);
    check({tag, "_done_one_cycle"}, 64'(done), 64'd0);
  endtask

  initial begin
    logic [W:0]   exp;
    logic         seen;
    logic         got;
    int           k;
    int           cyc;
    int           last_cyc;

    // Reset held with start high
    n_rst = 1'b0; start = 1'b1; a = 16'h1111; b = 16'h2222; carry_in = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_sum", 64'(sum), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    start = 1'b0;
    n_rst = 1'b1;
    @(negedge clk);

    run_op("basic", 16'h1234, 16'h4321, 1'b1);
    run_op("wrap", 16'hFFFF, 16'h0001, 1'b0);
    run_op("ripple", 16'h0FFF, 16'h0001, 1'b0);

    // Start pulsed while busy must be ignored, not queued
    @(negedge clk);
    a = 16'h0001; b = 16'h0001; carry_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 16'hFFFF; b = 16'hFFFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!done && k < 20) begin @(negedge clk); k++; end
    check("ignore_start_sum", 64'(sum), 64'h0002);
    check("ignore_start_ovf", 64'(overflow), 64'd0);
    seen = 1'b0;
    repeat (12) begin @(negedge clk); if (done) seen = 1'b1; end
    check("ignore_start_no_second_done", 64'(seen), 64'd0);

    // Reset during the second ADD cycle abandons the operation
    a = 16'h8000; b = 16'h8000; carry_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    n_rst = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_sum", 64'(sum), 64'd0);
    check("midrst_ovf", 64'(overflow), 64'd0);
    seen = 1'b0;
    repeat (8) begin @(negedge clk); if (done) seen = 1'b1; end
    check("midrst_no_done", 64'(seen), 64'd0);
    run_op("after_rst", 16'h8000, 16'h8000, 1'b0);

    // Randomized back-to-back run with start held high
    @(negedge clk);
    scramble();
    exp = (W+1)'(a) + (W+1)'(b) + (W+1)'(carry_in);
    start = 1'b1;
    cyc = 0;
    last_cyc = 0;
    for (int i = 0; i < 1000; i++) begin
      k = 0;
      got = 1'b0;
      while (!got && k < 20) begin
        @(negedge clk);
        cyc++;
        k++;
        if (done) got = 1'b1;
        else if (busy) scramble();
      end
      check("rand_done_seen", 64'(got), 64'd1);
      check("rand_sum", 64'(sum), 64'(exp[W-1:0]));
      check("rand_ovf", 64'(overflow), 64'(exp[W]));
      if (i > 0) check("rand_period", 64'(cyc - last_cyc), 64'(N + 2));
      last_cyc = cyc;
      scramble();
      exp = (W+1)'(a) + (W+1)'(b) + (W+1)'(carry_in);
    end
    start = 1'b0;
    repeat (10) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
